// File: rtl/imem_boot_loader_pkg.sv
// Shared types and sizes for the instruction-memory boot loader.
// Defines the FSM state encoding, counter widths and the IM write payload.
package imem_boot_loader_pkg;

  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CSUM_W    = 8;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } im_wr_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream, IM write and status signals of the boot loader.
// slave = loader side, master = upstream/host side.
interface imem_boot_loader_if;
  import imem_boot_loader_pkg::*;

  logic              start;
  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;
  logic              cpu_rstn;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  word_count;

  modport slave (
    input  start, byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata, cpu_rstn, busy, done, err, word_count
  );

  modport master (
    output start, byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_rstn, busy, done, err, word_count
  );

endinterface

// File: rtl/imem_boot_loader_byte_word_pack.sv
// Packs accepted bytes into little-endian 32-bit words; flags the 4th byte.
// The flagged word is presented combinationally so the caller can register it.
module imem_boot_loader_byte_word_pack
  import imem_boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_word_full_c,
  output logic [DATA_W-1:0] o_word_c
);

  localparam int unsigned ACC_W = DATA_W - BYTE_W;

  logic [1:0]       r_idx;
  logic [ACC_W-1:0] r_acc;

  // Lower three bytes shift down from the top so byte 0 ends up in [7:0]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= 2'd0;
      r_acc <= '0;
    end else if (i_clear) begin
      r_idx <= 2'd0;
      r_acc <= '0;
    end else if (i_push) begin
      r_idx <= r_idx + 2'd1;
      r_acc <= {i_byte, r_acc[ACC_W-1:BYTE_W]};
    end
  end

  assign o_word_full_c = i_push & (r_idx == 2'd3);
  assign o_word_c      = {i_byte, r_acc};

endmodule

// File: rtl/imem_boot_loader.sv
// Framed byte-stream loader for the instruction memory; holds the CPU in reset
// until a complete image with a matching checksum has been written.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
(
  input logic               clk,
  input logic               rst,
  imem_boot_loader_if.slave bus
);

  state_t             r_state;
  state_t             w_next;
  logic               w_xfer;
  logic               w_start_ok;
  logic               w_push;
  logic               w_full;
  logic               w_last_word;
  logic               w_next_load;
  logic [DATA_W-1:0]  w_word;
  logic [LEN_W-1:0]   w_len;
  logic [BYTE_W-1:0]  r_len_lo;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_wr_idx;
  logic [CNT_W-1:0]   r_word_count;
  logic [CSUM_W-1:0]  r_csum;
  im_wr_t             r_wr;
  logic               r_we;
  logic               r_byte_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_cpu_rstn;

  assign w_xfer      = bus.byte_valid & r_byte_ready;
  assign w_start_ok  = bus.start & (r_state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign w_push      = w_xfer & (r_state == ST_DATA);
  assign w_len       = {bus.byte_data, r_len_lo};
  assign w_last_word = w_full & ((r_wr_idx + CNT_W'(1)) == r_len);
  assign w_next_load = w_next inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM};

  imem_boot_loader_byte_word_pack u_pack (
    .clk           (clk),
    .rst           (rst),
    .i_clear       (w_start_ok),
    .i_push        (w_push),
    .i_byte        (bus.byte_data),
    .o_word_full_c (w_full),
    .o_word_c      (w_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (bus.start) w_next = ST_LEN0;
      ST_LEN0: if (w_xfer) w_next = ST_LEN1;
      ST_LEN1: begin
        if (w_xfer) begin
          if (w_len > LEN_W'(MAX_WORDS)) w_next = ST_ERR;
          else if (w_len == '0)          w_next = ST_CSUM;
          else                           w_next = ST_DATA;
        end
      end
      ST_DATA: if (w_last_word) w_next = ST_CSUM;
      ST_CSUM: begin
        if (w_xfer) w_next = (bus.byte_data == r_csum) ? ST_DONE : ST_ERR;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with r_state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_cpu_rstn   <= 1'b0;
    end else begin
      r_byte_ready <= w_next_load;
      r_busy       <= w_next_load;
      r_done       <= (w_next == ST_DONE);
      r_err        <= (w_next == ST_ERR);
      r_cpu_rstn   <= (w_next == ST_DONE);
    end
  end

  // Length, address, checksum and IM write register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len_lo     <= '0;
      r_len        <= '0;
      r_wr_idx     <= '0;
      r_word_count <= '0;
      r_csum       <= '0;
      r_wr         <= '0;
      r_we         <= 1'b0;
    end else begin
      r_we <= w_full;
      if (w_start_ok) begin
        r_len_lo     <= '0;
        r_len        <= '0;
        r_wr_idx     <= '0;
        r_word_count <= '0;
        r_csum       <= '0;
        r_wr         <= '0;
      end else begin
        if (w_xfer && (r_state == ST_LEN0)) r_len_lo <= bus.byte_data;
        if (w_xfer && (r_state == ST_LEN1)) r_len <= CNT_W'(w_len);
        if (w_push) r_csum <= r_csum + bus.byte_data;
        if (w_full) begin
          r_wr_idx <= r_wr_idx + CNT_W'(1);
          r_wr     <= '{addr: r_wr_idx[ADDR_W-1:0], data: w_word};
        end
        if (r_we) r_word_count <= r_word_count + CNT_W'(1);
      end
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.im_we      = r_we;
  assign bus.im_addr    = r_wr.addr;
  assign bus.im_wdata   = r_wr.data;
  assign bus.cpu_rstn   = r_cpu_rstn;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good/bad checksum, oversize length,
// empty image, stalled stream, reset mid-load and start while busy.
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_boot_loader_if bus();

  imem_boot_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nw     = 0;
  logic [ADDR_W-1:0] wr_addr [16];
  logic [DATA_W-1:0] wr_data [16];
  int                wr_cyc  [16];
  int                acc4 [$];
  logic [7:0]        pay  [$];

  // IM write monitor; cyc advances once per clock
  always @(negedge clk) begin
    if (bus.im_we && nw < 16) begin
      wr_addr[nw] = bus.im_addr;
      wr_data[nw] = bus.im_wdata;
      wr_cyc[nw]  = cyc;
      nw++;
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken
  task automatic send_byte(input logic [7:0] b, input bit is4th);
    int n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("byte_timeout", 32'd0, 32'd1);
      bus.byte_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (is4th) acc4.push_back(cyc);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic idle_cycle(input bit with_start);
    bus.start = with_start;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // cut >= 0 stops after that many payload bytes
  task automatic send_frame(input logic [15:0] n, input logic [7:0] cs,
                            input bit stall, input int cut);
    send_byte(n[7:0], 1'b0);
    send_byte(n[15:8], 1'b0);
    for (int i = 0; i < pay.size(); i++) begin
      if (cut >= 0 && i == cut) return;
      send_byte(pay[i], (i % 4) == 3);
      if (stall) idle_cycle(i == 0);
    end
    send_byte(cs, 1'b0);
  endtask

  task automatic load_prog();
    pay = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h02, 8'h10, 8'h00};
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready",  32'(bus.byte_ready), 32'd0);
    chk("rst_busy",   32'(bus.busy),       32'd0);
    chk("rst_done",   32'(bus.done),       32'd0);
    chk("rst_err",    32'(bus.err),        32'd0);
    chk("rst_cpurst", 32'(bus.cpu_rstn),   32'd0);
    chk("rst_we",     32'(bus.im_we),      32'd0);
    chk("rst_wcnt",   32'(bus.word_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Good image; payload byte sum 13+05+93+02+10 = 0xBD
    load_prog();
    nw = 0;
    pulse_start();
    chk("t1_busy",   32'(bus.busy),     32'd1);
    chk("t1_cpurst0", 32'(bus.cpu_rstn), 32'd0);
    send_frame(16'd2, 8'hBD, 1'b0, -1);
    chk("t1_cpurst_rise", 32'(bus.cpu_rstn), 32'd1);
    chk("t1_done",   32'(bus.done),       32'd1);
    repeat (2) @(negedge clk);
    chk("t1_err",    32'(bus.err),        32'd0);
    chk("t1_busy0",  32'(bus.busy),       32'd0);
    chk("t1_ready0", 32'(bus.byte_ready), 32'd0);
    chk("t1_wcnt",   32'(bus.word_count), 32'd2);
    chk("t1_nw",     32'(nw),             32'd2);
    chk("t1_addr0",  32'(wr_addr[0]),     32'd0);
    chk("t1_data0",  wr_data[0],          32'h0000_0513);
    chk("t1_addr1",  32'(wr_addr[1]),     32'd1);
    chk("t1_data1",  wr_data[1],          32'h0010_0293);

    // Restart from DONE clears status; bad checksum
    nw = 0;
    pulse_start();
    chk("t2_done_clr",   32'(bus.done),       32'd0);
    chk("t2_wcnt_clr",   32'(bus.word_count), 32'd0);
    chk("t2_cpurst_drop", 32'(bus.cpu_rstn),  32'd0);
    send_frame(16'd2, 8'h00, 1'b0, -1);
    repeat (2) @(negedge clk);
    chk("t2_err",    32'(bus.err),      32'd1);
    chk("t2_done",   32'(bus.done),     32'd0);
    chk("t2_cpurst", 32'(bus.cpu_rstn), 32'd0);
    chk("t2_nw",     32'(nw),           32'd2);
    chk("t2_data1",  wr_data[1],        32'h0010_0293);

    // Length 129 > capacity: error straight after LEN_HI
    nw = 0;
    pulse_start();
    send_byte(8'h81, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("t3_err",    32'(bus.err),        32'd1);
    chk("t3_ready",  32'(bus.byte_ready), 32'd0);
    chk("t3_busy",   32'(bus.busy),       32'd0);
    bus.byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("t3_nw",     32'(nw),             32'd0);
    chk("t3_err_hold", 32'(bus.err),      32'd1);

    // Empty image
    pay.delete();
    nw = 0;
    pulse_start();
    send_frame(16'd0, 8'h00, 1'b0, -1);
    chk("t4_done",   32'(bus.done),       32'd1);
    repeat (2) @(negedge clk);
    chk("t4_wcnt",   32'(bus.word_count), 32'd0);
    chk("t4_nw",     32'(nw),             32'd0);

    // Stalled stream with a start pulse during DATA (must be ignored)
    load_prog();
    nw = 0;
    acc4.delete();
    pulse_start();
    send_frame(16'd2, 8'hBD, 1'b1, -1);
    repeat (2) @(negedge clk);
    chk("t5_done",   32'(bus.done),       32'd1);
    chk("t5_wcnt",   32'(bus.word_count), 32'd2);
    chk("t5_nw",     32'(nw),             32'd2);
    chk("t5_data0",  wr_data[0],          32'h0000_0513);
    chk("t5_data1",  wr_data[1],          32'h0010_0293);
    chk("t5_acc4",   32'(acc4.size()),    32'd2);
    if (acc4.size() == 2) begin
      // im_we is sampled in the cycle right after the accepting edge
      chk("t5_we_lat0", 32'(wr_cyc[0]), 32'(acc4[0]));
      chk("t5_we_lat1", 32'(wr_cyc[1]), 32'(acc4[1]));
    end

    // Reset mid-load, then full reload
    nw = 0;
    pulse_start();
    send_frame(16'd2, 8'hBD, 1'b0, 5);
    chk("t6_pre_wcnt", 32'(bus.word_count), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_busy",   32'(bus.busy),       32'd0);
    chk("t6_ready",  32'(bus.byte_ready), 32'd0);
    chk("t6_wcnt",   32'(bus.word_count), 32'd0);
    chk("t6_cpurst", 32'(bus.cpu_rstn),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nw = 0;
    pulse_start();
    send_frame(16'd2, 8'hBD, 1'b0, -1);
    repeat (2) @(negedge clk);
    chk("t6_done",   32'(bus.done),       32'd1);
    chk("t6_cpurst1", 32'(bus.cpu_rstn),  32'd1);
    chk("t6_wcnt2",  32'(bus.word_count), 32'd2);
    chk("t6_data0",  wr_data[0],          32'h0000_0513);
    chk("t6_data1",  wr_data[1],          32'h0010_0293);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
